node_mem_responder: RTL and testbench

Memory-side responder for the per-node state store used by the EER-RL cluster-head logic. It holds a 2048 x 8-bit byte array and serves 16-bit word reads and writes to one initiator, such as the cluster-head decision block, through a req/ack handshake. Each word occupies two consecutive bytes in big-endian order. Every access takes a fixed number of cycles, so initiator FSMs can rely on deterministic timing.

---
 rtl/node_mem_responder.sv | 124 ++++++++++++
 tb/tb_node_mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/node_mem_responder.sv
// node_mem_responder
// Byte-organised 2048 x 8 state store serving big-endian 16-bit words to a
// single initiator. Every access has fixed latency: a good access is accepted
// in IDLE, touches the high byte in ACC_HI and the low byte in ACC_LO, then
// acknowledges in DONE. A word whose low byte would fall past the end of the
// array is rejected at capture and acknowledged with err one cycle later.
module node_mem_responder #(
    parameter int MEM_DEPTH  = 2048,
    parameter int MEM_WIDTH  = 8,
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  ack,
    output logic                  busy,
    output logic                  err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACC_HI = 2'd1;
    localparam logic [1:0] ACC_LO = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Highest byte address; a word starting here has no room for its low byte.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [1:0]            r_state;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_bad;
    logic [MEM_WIDTH-1:0]  r_hi_buf;
    logic [WORD_WIDTH-1:0] r_data_out;

    // Storage is deliberately left out of reset; contents are undefined until written.
    logic [MEM_WIDTH-1:0]  r_mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr_lo;
    logic                  w_addr_bad;
    logic [MEM_WIDTH-1:0]  w_wr_hi;
    logic [MEM_WIDTH-1:0]  w_wr_lo;

    // Low byte sits one above the captured address; bad addresses never reach
    // ACC_LO, so this never wraps in practice.
    assign w_addr_lo  = r_addr + ADDR_WIDTH'(1);
    assign w_addr_bad = (address == LAST_ADDR);
    assign w_wr_hi    = r_data[WORD_WIDTH-1 -: MEM_WIDTH];
    assign w_wr_lo    = r_data[MEM_WIDTH-1:0];

    // Status outputs decode straight from the state register.
    assign busy     = (r_state != IDLE);
    assign ack      = (r_state == DONE);
    assign err      = (r_state == DONE) && r_bad;
    assign data_out = r_data_out;

    // Access sequencer: capture in IDLE, walk the two byte phases, publish read data on entry to DONE.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_bad      <= 1'b0;
            r_hi_buf   <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_wr   <= wr_en;
                        r_addr <= address;
                        r_data <= data_in;
                        r_bad  <= w_addr_bad;
                        if (w_addr_bad) begin
                            // Rejected read reports zero rather than stale data.
                            if (!wr_en) begin
                                r_data_out <= '0;
                            end
                            r_state <= DONE;
                        end else begin
                            r_state <= ACC_HI;
                        end
                    end
                end
                ACC_HI: begin
                    if (!r_wr) begin
                        r_hi_buf <= r_mem[r_addr];
                    end
                    r_state <= ACC_LO;
                end
                ACC_LO: begin
                    // Low byte goes straight into data_out so it is valid for the whole ack cycle.
                    if (!r_wr) begin
                        r_data_out <= {r_hi_buf, r_mem[w_addr_lo]};
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Byte writes; gated by nrst so a reset during ACC_LO leaves the low byte untouched.
    always_ff @(posedge clk) begin
        if (nrst && r_wr && (r_state == ACC_HI)) begin
            r_mem[r_addr] <= w_wr_hi;
        end
        if (nrst && r_wr && (r_state == ACC_LO)) begin
            r_mem[w_addr_lo] <= w_wr_lo;
        end
    end

endmodule

// File: tb/tb_node_mem_responder.sv
// Bench for node_mem_responder: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_node_mem_responder;

    localparam int AW    = 11;
    localparam int DW    = 16;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          req = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          ack;
    logic          busy;
    logic          err;

    node_mem_responder dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .wr_en    (wr_en),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain byte array with written-flags.
    logic [7:0]  mdl [DEPTH];
    bit          vld [DEPTH];
    logic [15:0] exp_dout   = 16'h0000;
    bit          dout_known = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One access, started at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // Inputs are scrambled right after acceptance; poke raises a stray write req during ACC_LO.
    task automatic access(input bit wr, input logic [AW-1:0] a, input logic [15:0] d, input bit poke);
        int  lat;
        int  ai;
        bit  bad;
        ai  = int'(a);
        bad = (ai == DEPTH - 1);
        if (!wr) begin
            if (bad) begin
                exp_dout   = 16'h0000;
                dout_known = 1'b1;
            end else begin
                dout_known = vld[ai] && vld[ai+1];
                exp_dout   = {mdl[ai], mdl[ai+1]};
            end
        end
        req     = 1'b1;
        wr_en   = wr;
        address = a;
        data_in = d;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req     = 1'b0;
                address = AW'($urandom);
                data_in = DW'($urandom);
                wr_en   = ~wr;
            end
            if (poke && lat == 2) begin
                req     = 1'b1;
                wr_en   = 1'b1;
                address = 11'h030;
                data_in = 16'hDEAD;
            end
            if (poke && lat == 3) req = 1'b0;
            if (!ack) chk("busy_mid", busy, 1);
        end while (!ack && lat < 8);
        chk(bad ? "lat_bad" : "lat_good", lat, bad ? 1 : 3);
        chk("err", err, bad);
        chk("busy_ack", busy, 1);
        if (dout_known) chk(wr ? "dout_after_wr" : "dout_rd", data_out, exp_dout);
        if (wr && !bad) begin
            mdl[ai]   = d[15:8];
            mdl[ai+1] = d[7:0];
            vld[ai]   = 1'b1;
            vld[ai+1] = 1'b1;
        end
        @(negedge clk);
        chk("ack_drop", ack, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin : main
        int extra;
        for (int i = 0; i < DEPTH; i++) vld[i] = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", data_out, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Write then read
        access(1'b1, 11'h010, 16'hA55A, 1'b0);
        access(1'b0, 11'h010, 16'h0000, 1'b0);

        // Endianness and overlap: expect 0x1256
        access(1'b1, 11'h020, 16'h1234, 1'b0);
        access(1'b1, 11'h021, 16'h5678, 1'b0);
        access(1'b0, 11'h020, 16'h0000, 1'b0);
        chk("overlap_const", data_out, 16'h1256);

        // Boundary
        access(1'b1, 11'h000, 16'h9A3C, 1'b0);
        access(1'b1, 11'h7FE, 16'hBEEF, 1'b0);
        access(1'b0, 11'h7FE, 16'h0000, 1'b0);
        access(1'b0, 11'h7FF, 16'h0000, 1'b0);
        access(1'b1, 11'h7FF, 16'h7777, 1'b0);
        access(1'b0, 11'h000, 16'h0000, 1'b0);
        chk("no_wrap", data_out, 16'h9A3C);

        // Busy ignore: stray write req to 0x030 during ACC_LO of a read
        access(1'b1, 11'h030, 16'h1111, 1'b0);
        access(1'b0, 11'h010, 16'h0000, 1'b1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) extra++;
        end
        chk("no_extra_ack", extra, 0);
        access(1'b0, 11'h030, 16'h0000, 1'b0);

        // Reset mid-write: only the high byte lands
        access(1'b1, 11'h040, 16'h0000, 1'b0);
        access(1'b0, 11'h010, 16'h0000, 1'b0);
        req     = 1'b1;
        wr_en   = 1'b1;
        address = 11'h040;
        data_in = 16'hCAFE;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("mrst_ack", ack, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err, 0);
        chk("mrst_dout", data_out, 0);
        nrst       = 1'b1;
        mdl[16'h40] = 8'hCA;
        exp_dout   = 16'h0000;
        dout_known = 1'b1;
        access(1'b0, 11'h040, 16'h0000, 1'b0);
        chk("mrst_readback", data_out, 16'hCA00);

        // Randomized traffic over a prefilled window plus the bad address
        for (int a = 16'h100; a <= 16'h140; a += 2)
            access(1'b1, AW'(a), DW'($urandom), 1'b0);
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] ra;
            if ($urandom_range(0, 7) == 0) ra = 11'h7FF;
            else ra = AW'(16'h100 + $urandom_range(0, 16'h3F));
            access(1'($urandom_range(0, 1)), ra, DW'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
